// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU opcodes, forward-select encodings and the E-stage control bundle
// used by the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int ALU_OP_LENGTH = 4;

    typedef logic [ALU_OP_LENGTH-1:0] alu_op_t;
    typedef logic [WORD_WIDTH-1:0]    word_t;

    // ALU_NOP must stay all-zero so a bubble drives a zero ALU result
    localparam alu_op_t ALU_NOP = 4'd0;
    localparam alu_op_t ALU_ADD = 4'd1;
    localparam alu_op_t ALU_SUB = 4'd2;
    localparam alu_op_t ALU_AND = 4'd3;
    localparam alu_op_t ALU_OR  = 4'd4;
    localparam alu_op_t ALU_XOR = 4'd5;
    localparam alu_op_t ALU_NOR = 4'd6;
    localparam alu_op_t ALU_SLT = 4'd7;
    localparam alu_op_t ALU_SLL = 4'd8;
    localparam alu_op_t ALU_SRL = 4'd9;
    localparam alu_op_t ALU_SRA = 4'd10;
    localparam alu_op_t ALU_LUI = 4'd11;

    localparam word_t ZEROWORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_M   = 2'd1,
        FWD_W   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic    valid;
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_write;
        logic    reg_dst;
        logic    alu_src_b_imm;
        logic    alu_src_a_shamt;
        alu_op_t alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        valid:           1'b0,
        reg_write:       1'b0,
        mem_to_reg:      1'b0,
        mem_write:       1'b0,
        reg_dst:         1'b0,
        alu_src_b_imm:   1'b0,
        alu_src_a_shamt: 1'b0,
        alu_op:          ALU_NOP
    };

    function automatic word_t shamt_word(input logic [4:0] shamt);
        return {27'd0, shamt};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, M/W forward sources and the execute-side outputs of the ID/EX stage.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic       stallE, flushE;
    logic       validD, regWriteD, memToRegD, memWriteD;
    logic       regDstD, aluSrcBImmD, aluSrcAShamtD;
    alu_op_t    aluOpD;
    logic [4:0] rsD, rtD, rdD, shamtD;
    word_t      rsDataD, rtDataD, immD;

    logic       regWriteM;
    logic [4:0] writeRegM;
    word_t      aluOutM;
    logic       regWriteW;
    logic [4:0] writeRegW;
    word_t      resultW;

    alu_op_t    aluOpE;
    word_t      SrcA, SrcB, writeDataE;
    logic [4:0] writeRegE, rsE, rtE;
    logic       validE, regWriteE, memToRegE, memWriteE;

    modport master (
        output stallE, flushE, validD, regWriteD, memToRegD, memWriteD,
               regDstD, aluSrcBImmD, aluSrcAShamtD, aluOpD,
               rsD, rtD, rdD, shamtD, rsDataD, rtDataD, immD,
               regWriteM, writeRegM, aluOutM, regWriteW, writeRegW, resultW,
        input  aluOpE, SrcA, SrcB, writeDataE, writeRegE, rsE, rtE,
               validE, regWriteE, memToRegE, memWriteE
    );

    modport slave (
        input  stallE, flushE, validD, regWriteD, memToRegD, memWriteD,
               regDstD, aluSrcBImmD, aluSrcAShamtD, aluOpD,
               rsD, rtD, rdD, shamtD, rsDataD, rtDataD, immD,
               regWriteM, writeRegM, aluOutM, regWriteW, writeRegW, resultW,
        output aluOpE, SrcA, SrcB, writeDataE, writeRegE, rsE, rtE,
               validE, regWriteE, memToRegE, memWriteE
    );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Per-operand forwarding: compares one specifier against the M and W destinations
// and picks the newest value; M beats W and $0 is never forwarded.
module id_ex_stage_fwd_sel
    import id_ex_stage_pkg::*;
(
    input  logic [4:0] spec,
    input  word_t      reg_data,
    input  logic       reg_write_m,
    input  logic [4:0] write_reg_m,
    input  word_t      alu_out_m,
    input  logic       reg_write_w,
    input  logic [4:0] write_reg_w,
    input  word_t      result_w,
    output word_t      fwd_data
);

    fwd_sel_t sel_s;

    // Forward source priority decision
    always_comb begin
        sel_s = FWD_REG;
        if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == spec)) begin
            sel_s = FWD_M;
        end else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == spec)) begin
            sel_s = FWD_W;
        end else begin
            sel_s = FWD_REG;
        end
    end

    // 3:1 operand mux
    always_comb begin
        fwd_data = reg_data;
        case (sel_s)
            FWD_M:   fwd_data = alu_out_m;
            FWD_W:   fwd_data = result_w;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, plus forwarding and ALU operand selection
// for the execute stage.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    ctrl_t      ctrl_r;
    logic [4:0] rs_r, rt_r, rd_r, shamt_r;
    word_t      rs_data_r, rt_data_r, imm_r;
    word_t      fwd_rs_s, fwd_rt_s;

    id_ex_stage_fwd_sel u_fwd_rs (
        .spec        (rs_r),
        .reg_data    (rs_data_r),
        .reg_write_m (bus.regWriteM),
        .write_reg_m (bus.writeRegM),
        .alu_out_m   (bus.aluOutM),
        .reg_write_w (bus.regWriteW),
        .write_reg_w (bus.writeRegW),
        .result_w    (bus.resultW),
        .fwd_data    (fwd_rs_s)
    );

    id_ex_stage_fwd_sel u_fwd_rt (
        .spec        (rt_r),
        .reg_data    (rt_data_r),
        .reg_write_m (bus.regWriteM),
        .write_reg_m (bus.writeRegM),
        .alu_out_m   (bus.aluOutM),
        .reg_write_w (bus.regWriteW),
        .write_reg_w (bus.writeRegW),
        .result_w    (bus.resultW),
        .fwd_data    (fwd_rt_s)
    );

    // E register: reset, then bubble, then hold with refreshed operands, then load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r    <= CTRL_BUBBLE;
            rs_r      <= 5'd0;
            rt_r      <= 5'd0;
            rd_r      <= 5'd0;
            shamt_r   <= 5'd0;
            rs_data_r <= ZEROWORD;
            rt_data_r <= ZEROWORD;
            imm_r     <= ZEROWORD;
        end else if (bus.flushE) begin
            ctrl_r    <= CTRL_BUBBLE;
            rs_r      <= 5'd0;
            rt_r      <= 5'd0;
            rd_r      <= 5'd0;
            shamt_r   <= 5'd0;
            rs_data_r <= ZEROWORD;
            rt_data_r <= ZEROWORD;
            imm_r     <= ZEROWORD;
        end else if (bus.stallE) begin
            // a W producer retiring during the stall must not be lost
            rs_data_r <= fwd_rs_s;
            rt_data_r <= fwd_rt_s;
        end else begin
            ctrl_r.valid           <= bus.validD;
            ctrl_r.reg_write       <= bus.regWriteD & bus.validD;
            ctrl_r.mem_to_reg      <= bus.memToRegD & bus.validD;
            ctrl_r.mem_write       <= bus.memWriteD & bus.validD;
            ctrl_r.reg_dst         <= bus.regDstD;
            ctrl_r.alu_src_b_imm   <= bus.aluSrcBImmD;
            ctrl_r.alu_src_a_shamt <= bus.aluSrcAShamtD;
            ctrl_r.alu_op          <= bus.aluOpD;
            rs_r                   <= bus.rsD;
            rt_r                   <= bus.rtD;
            rd_r                   <= bus.rdD;
            shamt_r                <= bus.shamtD;
            rs_data_r              <= bus.rsDataD;
            rt_data_r              <= bus.rtDataD;
            imm_r                  <= bus.immD;
        end
    end

    assign bus.SrcA       = ctrl_r.alu_src_a_shamt ? shamt_word(shamt_r) : fwd_rs_s;
    assign bus.SrcB       = ctrl_r.alu_src_b_imm ? imm_r : fwd_rt_s;
    assign bus.writeDataE = fwd_rt_s;
    assign bus.writeRegE  = ctrl_r.reg_dst ? rd_r : rt_r;
    assign bus.aluOpE     = ctrl_r.alu_op;
    assign bus.rsE        = rs_r;
    assign bus.rtE        = rt_r;
    assign bus.validE     = ctrl_r.valid;
    assign bus.regWriteE  = ctrl_r.reg_write;
    assign bus.memToRegE  = ctrl_r.mem_to_reg;
    assign bus.memWriteE  = ctrl_r.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding priority, $0, shamt/imm
// selection, stall refresh, flush-over-stall and asynchronous reset.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.stallE = 1'b0;        bus.flushE = 1'b0;
        bus.validD = 1'b0;        bus.regWriteD = 1'b0;
        bus.memToRegD = 1'b0;     bus.memWriteD = 1'b0;
        bus.regDstD = 1'b0;       bus.aluSrcBImmD = 1'b0;
        bus.aluSrcAShamtD = 1'b0; bus.aluOpD = ALU_NOP;
        bus.rsD = 5'd0; bus.rtD = 5'd0; bus.rdD = 5'd0; bus.shamtD = 5'd0;
        bus.rsDataD = 32'h0; bus.rtDataD = 32'h0; bus.immD = 32'h0;
        bus.regWriteM = 1'b0; bus.writeRegM = 5'd0; bus.aluOutM = 32'h0;
        bus.regWriteW = 1'b0; bus.writeRegW = 5'd0; bus.resultW = 32'h0;

        #3;
        chk("rst_validE", bus.validE, 32'd0);
        chk("rst_aluOpE", bus.aluOpE, 32'(ALU_NOP));
        chk("rst_SrcA", bus.SrcA, 32'h0);
        chk("rst_SrcB", bus.SrcB, 32'h0);
        chk("rst_writeRegE", bus.writeRegE, 32'd0);
        #9 rst_n = 1'b1;

        // basic load: ADD with rs data 5, rt data 7, rd = 4
        bus.validD = 1'b1; bus.regWriteD = 1'b1; bus.regDstD = 1'b1;
        bus.aluOpD = ALU_ADD;
        bus.rsD = 5'd1; bus.rtD = 5'd2; bus.rdD = 5'd4;
        bus.rsDataD = 32'd5; bus.rtDataD = 32'd7;
        step();
        chk("load_SrcA", bus.SrcA, 32'd5);
        chk("load_SrcB", bus.SrcB, 32'd7);
        chk("load_validE", bus.validE, 32'd1);
        chk("load_regWriteE", bus.regWriteE, 32'd1);
        chk("load_writeRegE", bus.writeRegE, 32'd4);
        chk("load_aluOpE", bus.aluOpE, 32'(ALU_ADD));
        chk("load_rsE", bus.rsE, 32'd1);
        chk("load_rtE", bus.rtE, 32'd2);

        // M beats W on the same register; then W alone; then registered value
        bus.rsD = 5'd3; bus.rsDataD = 32'h99; bus.rtD = 5'd6; bus.rtDataD = 32'h66;
        step();
        bus.regWriteM = 1'b1; bus.writeRegM = 5'd3; bus.aluOutM = 32'h11;
        bus.regWriteW = 1'b1; bus.writeRegW = 5'd3; bus.resultW = 32'h22;
        #1;
        chk("fwd_M_over_W", bus.SrcA, 32'h11);
        chk("fwd_rt_untouched", bus.SrcB, 32'h66);
        bus.regWriteM = 1'b0;
        #1;
        chk("fwd_W", bus.SrcA, 32'h22);
        bus.regWriteW = 1'b0;
        #1;
        chk("fwd_none", bus.SrcA, 32'h99);

        // $0 is never forwarded
        bus.rsD = 5'd0; bus.rsDataD = 32'h0; bus.rtD = 5'd0; bus.rtDataD = 32'h0;
        bus.regWriteM = 1'b1; bus.writeRegM = 5'd0; bus.aluOutM = 32'hFFFF;
        bus.regWriteW = 1'b1; bus.writeRegW = 5'd0; bus.resultW = 32'h1234;
        step();
        chk("zero_SrcA", bus.SrcA, 32'h0);
        chk("zero_SrcB", bus.SrcB, 32'h0);
        bus.regWriteM = 1'b0; bus.regWriteW = 1'b0;

        // sll: SrcA from shamt, SrcB from rt
        bus.aluOpD = ALU_SLL; bus.aluSrcAShamtD = 1'b1; bus.shamtD = 5'd4;
        bus.rsD = 5'd9; bus.rsDataD = 32'hDEAD; bus.rtD = 5'd2; bus.rtDataD = 32'h1;
        bus.rdD = 5'd8;
        step();
        chk("sll_SrcA", bus.SrcA, 32'd4);
        chk("sll_SrcB", bus.SrcB, 32'd1);
        chk("sll_writeRegE", bus.writeRegE, 32'd8);

        // sw: SrcB = imm, store data forwarded from W, destination = rt
        bus.aluOpD = ALU_ADD; bus.aluSrcAShamtD = 1'b0; bus.aluSrcBImmD = 1'b1;
        bus.immD = 32'd8; bus.rsD = 5'd4; bus.rsDataD = 32'h100;
        bus.rtD = 5'd5; bus.rtDataD = 32'h0;
        bus.regWriteD = 1'b0; bus.memWriteD = 1'b1; bus.regDstD = 1'b0;
        step();
        bus.regWriteW = 1'b1; bus.writeRegW = 5'd5; bus.resultW = 32'hAB;
        #1;
        chk("sw_SrcB", bus.SrcB, 32'd8);
        chk("sw_writeDataE", bus.writeDataE, 32'hAB);
        chk("sw_SrcA", bus.SrcA, 32'h100);
        chk("sw_memWriteE", bus.memWriteE, 32'd1);
        chk("sw_regWriteE", bus.regWriteE, 32'd0);
        chk("sw_writeRegE", bus.writeRegE, 32'd5);
        bus.regWriteW = 1'b0;

        // stall two cycles; W forwards 0x55 to rt only during the first
        bus.aluOpD = ALU_SUB; bus.aluSrcBImmD = 1'b0; bus.memWriteD = 1'b0;
        bus.regWriteD = 1'b1; bus.memToRegD = 1'b1; bus.regDstD = 1'b1;
        bus.rsD = 5'd1; bus.rsDataD = 32'h10; bus.rtD = 5'd7; bus.rtDataD = 32'h70;
        bus.rdD = 5'd12;
        step();
        chk("pre_stall_SrcB", bus.SrcB, 32'h70);
        bus.aluOpD = ALU_AND; bus.rtD = 5'd9; bus.rtDataD = 32'hEEEE;
        bus.rdD = 5'd13; bus.memToRegD = 1'b0;
        bus.stallE = 1'b1;
        bus.regWriteW = 1'b1; bus.writeRegW = 5'd7; bus.resultW = 32'h55;
        #1;
        chk("stall_c1_SrcB", bus.SrcB, 32'h55);
        step();
        bus.regWriteW = 1'b0;
        #1;
        chk("stall_kept_SrcB", bus.SrcB, 32'h55);
        chk("stall_rtE", bus.rtE, 32'd7);
        step();
        chk("stall_c2_SrcB", bus.SrcB, 32'h55);
        chk("stall_c2_SrcA", bus.SrcA, 32'h10);
        chk("stall_c2_aluOpE", bus.aluOpE, 32'(ALU_SUB));
        chk("stall_c2_writeRegE", bus.writeRegE, 32'd12);
        chk("stall_c2_memToRegE", bus.memToRegE, 32'd1);
        chk("stall_c2_regWriteE", bus.regWriteE, 32'd1);
        chk("stall_c2_validE", bus.validE, 32'd1);

        // flush and stall together: flush wins
        bus.flushE = 1'b1;
        step();
        chk("flush_validE", bus.validE, 32'd0);
        chk("flush_regWriteE", bus.regWriteE, 32'd0);
        chk("flush_memWriteE", bus.memWriteE, 32'd0);
        chk("flush_memToRegE", bus.memToRegE, 32'd0);
        chk("flush_aluOpE", bus.aluOpE, 32'(ALU_NOP));
        chk("flush_SrcA", bus.SrcA, 32'h0);
        chk("flush_SrcB", bus.SrcB, 32'h0);
        chk("flush_writeRegE", bus.writeRegE, 32'd0);

        // reload, then asynchronous reset in the middle of a stall
        bus.flushE = 1'b0; bus.stallE = 1'b0;
        step();
        chk("reload_validE", bus.validE, 32'd1);
        chk("reload_SrcB", bus.SrcB, 32'hEEEE);
        chk("reload_writeRegE", bus.writeRegE, 32'd13);
        bus.stallE = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_validE", bus.validE, 32'd0);
        chk("arst_regWriteE", bus.regWriteE, 32'd0);
        chk("arst_aluOpE", bus.aluOpE, 32'(ALU_NOP));
        chk("arst_SrcA", bus.SrcA, 32'h0);
        chk("arst_SrcB", bus.SrcB, 32'h0);
        chk("arst_writeRegE", bus.writeRegE, 32'd0);
        step();
        rst_n = 1'b1;
        bus.stallE = 1'b0;
        step();
        chk("post_rst_validE", bus.validE, 32'd1);
        chk("post_rst_aluOpE", bus.aluOpE, 32'(ALU_AND));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
